// File: rtl/pixel_job_scheduler.sv
// -----------------------------------------------------------------------------
// pixel_job_scheduler
//
// Walks a frame in raster order and hands each pixel (x, y) to one of NCORE
// raymarching cores. Cores are picked round-robin, each core holds at most one
// job, and the block tracks in-flight jobs so it can report frame completion
// and flag a frame_start that arrives before the previous frame has finished.
//
// Parameters:
//   H_RES  active pixels per line  (<= 1024)
//   V_RES  active lines per frame  (<= 1024)
//   NCORE  number of cores         (2..16)
//
// Ports:
//   clk_pix      in   1      pixel clock
//   rst_pix_n    in   1      synchronous active-low reset
//   frame_start  in   1      one-cycle pulse, start a new frame
//   job_valid    out  NCORE  one-hot job offer, bit i targets core i
//   job_ready    in   NCORE  core i accepts the offered job
//   job_x        out  10     pixel x of the offered job
//   job_y        out  10     pixel y of the offered job
//   job_done     in   NCORE  one-cycle pulse, core i finished its job
//   core_busy    out  NCORE  core i holds an accepted, unfinished job
//   busy         out  1      frame in progress (dispatching or draining)
//   frame_done   out  1      one-cycle pulse, every job of the frame finished
//   overrun      out  1      sticky, frame_start seen while busy
// -----------------------------------------------------------------------------
module pixel_job_scheduler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int NCORE = 4
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             frame_start,
    output logic [NCORE-1:0] job_valid,
    input  logic [NCORE-1:0] job_ready,
    output logic [9:0]       job_x,
    output logic [9:0]       job_y,
    input  logic [NCORE-1:0] job_done,
    output logic [NCORE-1:0] core_busy,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam int PTR_W = $clog2(NCORE);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;

    localparam logic [9:0]       LAST_X    = 10'(H_RES - 1);
    localparam logic [9:0]       LAST_Y    = 10'(V_RES - 1);
    localparam logic [PTR_W:0]   NCORE_W   = (PTR_W + 1)'(NCORE);
    localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(NCORE - 1);

    logic [1:0]       r_state;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [PTR_W-1:0] r_ptr;
    logic [NCORE-1:0] r_valid;
    logic [NCORE-1:0] r_core_busy;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_overrun;

    logic [NCORE-1:0] w_xfer;
    logic             w_xfer_any;
    logic             w_last_px;
    logic [NCORE-1:0] w_busy_next;
    logic [NCORE-1:0] w_elig_rot;
    logic [PTR_W:0]   w_sum;
    logic             w_grant_ok;
    logic [PTR_W-1:0] w_grant_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic [NCORE-1:0] w_grant;

    // A transfer happens where the registered offer meets ready.
    assign w_xfer     = r_valid & job_ready;
    assign w_xfer_any = |w_xfer;
    assign w_last_px  = (r_x == LAST_X) && (r_y == LAST_Y);

    // Occupancy after this edge: done clears, a transfer sets, and a transfer
    // to the same core wins over its done. A done on an idle core is a no-op.
    assign w_busy_next = (r_core_busy & ~job_done) | w_xfer;

    // Round-robin search: rotate the eligible vector so the pointer sits at
    // bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        w_elig_rot = NCORE'({~w_busy_next, ~w_busy_next} >> r_ptr);
        w_grant_ok = 1'b0;
        w_sum      = '0;
        // Descending scan so the lowest eligible offset is the last to write.
        for (int k = NCORE - 1; k >= 0; k--) begin
            if (w_elig_rot[k]) begin
                w_grant_ok = 1'b1;
                w_sum      = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            end
        end
    end

    always_comb begin
        if (w_sum >= NCORE_W) begin
            w_grant_idx = PTR_W'(w_sum - NCORE_W);
        end else begin
            w_grant_idx = w_sum[PTR_W-1:0];
        end
    end

    assign w_ptr_next = (w_grant_idx == LAST_CORE) ? '0 : w_grant_idx + PTR_W'(1);
    assign w_grant    = w_grant_ok ? (NCORE'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            // NOTE: this block holds only control flops (no storage arrays), so
            // every register is cleared; abandoning a frame forgets all jobs.
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_ptr        <= '0;
            r_valid      <= '0;
            r_core_busy  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_frame_done <= 1'b0;
            r_core_busy  <= w_busy_next;

            if (frame_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_x <= '0;
                    r_y <= '0;
                    if (frame_start) begin
                        r_state <= S_DISPATCH;
                        r_busy  <= 1'b1;
                        r_valid <= w_grant;
                        if (w_grant_ok) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end

                S_DISPATCH: begin
                    if (w_xfer_any && w_last_px) begin
                        r_state <= S_DRAIN;
                        r_valid <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else if (w_xfer_any || (r_valid == '0)) begin
                        // Either the offer was taken (advance and re-offer) or
                        // nothing is on offer (retry). A pending offer is held.
                        if (w_xfer_any) begin
                            if (r_x == LAST_X) begin
                                r_x <= '0;
                                r_y <= r_y + 10'd1;
                            end else begin
                                r_x <= r_x + 10'd1;
                            end
                        end
                        r_valid <= w_grant;
                        if (w_grant_ok) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_busy_next == '0) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= '0;
                end
            endcase
        end
    end

    assign job_valid  = r_valid;
    assign job_x      = r_x;
    assign job_y      = r_y;
    assign core_busy  = r_core_busy;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pixel_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pixel_job_scheduler
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (pixel index, per-core occupancy flags, round-robin pointer) predicts every
// output after each clock edge; outputs are sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_pixel_job_scheduler;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int N    = 2;
    localparam int NPIX = H * V;

    logic         clk_pix     = 1'b0;
    logic         rst_pix_n   = 1'b0;
    logic         frame_start = 1'b0;
    logic [N-1:0] job_ready   = '0;
    logic [N-1:0] job_done    = '0;
    logic [N-1:0] job_valid;
    logic [N-1:0] core_busy;
    logic [9:0]   job_x;
    logic [9:0]   job_y;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: phase 0 idle, 1 dispatching, 2 draining.
    int         m_phase = 0;
    int         m_core  = -1;   // core currently offered a job, -1 for none
    int         m_pix   = 0;    // raster index of the offered / next pixel
    int         m_ptr   = 0;
    bit [N-1:0] m_busy  = '0;
    bit         m_fd    = 1'b0;
    bit         m_ovr   = 1'b0;

    // Transfer observed on the DUT just before the most recent edge.
    logic [N-1:0] obs_xfer;
    logic [9:0]   obs_x;
    logic [9:0]   obs_y;

    pixel_job_scheduler #(
        .H_RES (H),
        .V_RES (V),
        .NCORE (N)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix_n   (rst_pix_n),
        .frame_start (frame_start),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_done    (job_done),
        .core_busy   (core_busy),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer the current pixel to the first free core at or after the pointer.
    task automatic m_offer();
        int c;
        m_core = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if ((m_core < 0) && !m_busy[c]) m_core = c;
        end
        if (m_core >= 0) m_ptr = (m_core + 1) % N;
    endtask

    task automatic model_edge();
        bit xfer;
        if (!rst_pix_n) begin
            m_phase = 0;
            m_core  = -1;
            m_pix   = 0;
            m_ptr   = 0;
            m_busy  = '0;
            m_fd    = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        xfer = 1'b0;
        if (m_core >= 0) xfer = job_ready[m_core];
        for (int c = 0; c < N; c++) begin
            if (job_done[c]) m_busy[c] = 1'b0;
        end
        if (xfer) m_busy[m_core] = 1'b1;
        m_fd = 1'b0;
        if (frame_start && (m_phase != 0)) m_ovr = 1'b1;
        case (m_phase)
            0: begin
                if (frame_start) begin
                    m_phase = 1;
                    m_pix   = 0;
                    m_offer();
                end
            end
            1: begin
                if (xfer) begin
                    if (m_pix == NPIX - 1) begin
                        m_phase = 2;
                        m_core  = -1;
                    end else begin
                        m_pix++;
                        m_offer();
                    end
                end else if (m_core < 0) begin
                    m_offer();
                end
            end
            default: begin
                if (m_busy == '0) begin
                    m_phase = 0;
                    m_fd    = 1'b1;
                end
            end
        endcase
    endtask

    // One clock: record the pre-edge transfer, advance the model, compare.
    task automatic step();
        obs_xfer = job_valid & job_ready;
        obs_x    = job_x;
        obs_y    = job_y;
        @(posedge clk_pix);
        model_edge();
        #1;
        check("job_valid", 32'(job_valid), (m_core >= 0) ? (32'd1 << m_core) : 32'd0);
        check("core_busy", 32'(core_busy), 32'(m_busy));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_core >= 0) begin
            check("job_x", 32'(job_x), 32'(m_pix % H));
            check("job_y", 32'(job_y), 32'(m_pix / H));
        end
    endtask

    // Run the current frame to completion, each core finishing one cycle
    // after it accepted; returns in the frame_done cycle.
    task automatic finish_frame(input string tag);
        bit seen;
        seen      = 1'b0;
        job_ready = '1;
        for (int cyc = 0; (cyc < 64) && !seen; cyc++) begin
            job_done = core_busy;
            step();
            if (frame_done) seen = 1'b1;
        end
        job_done = '0;
        check({tag, "_frame_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers;
        int fd_cyc;
        int fds;

        // Reset held with frame_start high.
        rst_pix_n   = 1'b0;
        frame_start = 1'b1;
        repeat (3) step();
        check("rst_valid", 32'(job_valid), 32'd0);
        check("rst_core_busy", 32'(core_busy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        rst_pix_n   = 1'b1;
        frame_start = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid", 32'(job_valid), 32'd1);
        check("start_x", 32'(job_x), 32'd0);
        check("start_y", 32'(job_y), 32'd0);

        // Full-speed dispatch with one-cycle completion.
        job_ready = '1;
        xfers     = 0;
        fd_cyc    = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            job_done = core_busy;
            step();
            if (obs_xfer != '0) begin
                check("fs_core", 32'(obs_xfer), (xfers % 2 == 0) ? 32'd1 : 32'd2);
                check("fs_x", 32'(obs_x), 32'(xfers % H));
                check("fs_y", 32'(obs_y), 32'(xfers / H));
                check("fs_edge", 32'(cyc), 32'(xfers));
                xfers++;
            end
            if (frame_done) begin
                fd_cyc = cyc;
                break;
            end
        end
        job_done = '0;
        check("fs_xfers", 32'(xfers), 32'(NPIX));
        check("fs_fd_edge", 32'(fd_cyc), 32'(NPIX));
        fds = 0;
        repeat (3) begin
            step();
            if (frame_done) fds++;
        end
        check("fs_fd_extra", 32'(fds), 32'd0);

        // Stall on core 0.
        job_ready   = 2'b10;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("stall_grant", 32'(job_valid), 32'd1);
        repeat (5) begin
            step();
            check("stall_hold_valid", 32'(job_valid), 32'd1);
            check("stall_hold_x", 32'(job_x), 32'd0);
            check("stall_hold_y", 32'(job_y), 32'd0);
        end
        job_ready = 2'b11;
        step();
        check("stall_release", 32'(obs_xfer), 32'd1);
        check("stall_next_x", 32'(job_x), 32'd1);
        finish_frame("stall");

        // All cores occupied, no completions.
        job_ready   = '1;
        job_done    = '0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        xfers       = 0;
        repeat (6) begin
            step();
            if (obs_xfer != '0) xfers++;
        end
        check("full_xfers", 32'(xfers), 32'd2);
        check("full_valid", 32'(job_valid), 32'd0);
        check("full_core_busy", 32'(core_busy), 32'd3);
        job_done = 2'b10;
        step();
        job_done = '0;
        check("full_regrant", 32'(job_valid), 32'd2);
        finish_frame("full");

        // Spurious done and early frame_start.
        job_ready   = '0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        job_done    = '1;
        step();
        job_done    = '0;
        check("spur_core_busy", 32'(core_busy), 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_x", 32'(job_x), 32'd0);
        check("ovr_y", 32'(job_y), 32'd0);
        step();
        check("ovr_hold", 32'(overrun), 32'd1);
        finish_frame("ovr");
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset during drain.
        rst_pix_n = 1'b0;
        step();
        rst_pix_n = 1'b1;
        step();
        check("clr_overrun", 32'(overrun), 32'd0);
        job_ready   = '1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        xfers       = 0;
        for (int cyc = 0; (cyc < 30) && (xfers < NPIX); cyc++) begin
            job_done = core_busy;
            step();
            if (obs_xfer != '0) xfers++;
        end
        job_done = '0;
        check("drain_xfers", 32'(xfers), 32'(NPIX));
        step();
        check("drain_busy", 32'(busy), 32'd1);
        rst_pix_n = 1'b0;
        step();
        rst_pix_n = 1'b1;
        check("mid_rst_valid", 32'(job_valid), 32'd0);
        check("mid_rst_core_busy", 32'(core_busy), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        fds      = 0;
        job_done = '1;
        step();
        if (frame_done) fds++;
        job_done = '0;
        repeat (4) begin
            step();
            if (frame_done) fds++;
        end
        check("mid_rst_no_fd", 32'(fds), 32'd0);

        // Back-to-back frames.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        finish_frame("b2b_first");
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid_any", 32'(|job_valid), 32'd1);
        check("b2b_x", 32'(job_x), 32'd0);
        check("b2b_y", 32'(job_y), 32'd0);
        check("b2b_overrun", 32'(overrun), 32'd0);
        finish_frame("b2b_second");

        // Randomized traffic, including rare resets and early frame_starts.
        for (int i = 0; i < 400; i++) begin
            rst_pix_n   = ($urandom_range(0, 149) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            job_ready   = N'($urandom);
            job_done    = N'($urandom) & N'($urandom);
            step();
        end
        rst_pix_n   = 1'b1;
        frame_start = 1'b0;
        job_done    = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
